// File: rtl/button_ctrl_unit.sv
// Front-panel button stage for the time-clock datapath.
// Each raw pushbutton is synchronised, debounced and edge-detected into a
// single-cycle press pulse. The mode pulse toggles the display select; the
// run and clear pulses drive a small run/stop/clear FSM whose outputs gate
// and clear the downstream time counter.

// One button channel: 2-flop synchroniser, debounce counter, rising-edge pulse.
module button_ctrl_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_btn,
   output logic press_pulse
);

   // Counter only has to reach DEBOUNCE_CYCLES-1, so clog2 of the count is enough.
   localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             sync_meta_r;
   logic             sync_r;
   logic             level_r;
   logic             level_d_r;
   logic [CNT_W-1:0] cnt_r;

   // Synchroniser, debounce counter and delayed level for edge detection.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sync_meta_r <= 1'b0;
         sync_r      <= 1'b0;
         level_r     <= 1'b0;
         level_d_r   <= 1'b0;
         cnt_r       <= '0;
      end else begin
         sync_meta_r <= i_btn;
         sync_r      <= sync_meta_r;
         level_d_r   <= level_r;
         if (sync_r == level_r) begin
            // Agreement (or a bounce back) throws away any partial count.
            cnt_r <= '0;
         end else if (cnt_r == CNT_MAX) begin
            // Held different for the full window: accept the new level.
            level_r <= sync_r;
            cnt_r   <= '0;
         end else begin
            cnt_r <= cnt_r + CNT_ONE;
         end
      end
   end

   // Both operands are flops, so the pulse is glitch-free and lasts one cycle.
   assign press_pulse = level_r & ~level_d_r;

endmodule


module button_ctrl_unit #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_btn_mode,
   input  logic       i_btn_run,
   input  logic       i_btn_clear,
   output logic       o_modeSW,
   output logic       o_run,
   output logic       o_clear,
   output logic [1:0] o_state
);

   localparam logic [1:0] ST_STOP  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_CLEAR = 2'd2;

   logic       mode_press_s;
   logic       run_press_s;
   logic       clear_press_s;
   logic [1:0] state_next_s;
   logic [1:0] state_r;
   logic       mode_r;
   logic       run_r;
   logic       clear_r;

   button_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_btn       (i_btn_mode),
      .press_pulse (mode_press_s)
   );

   button_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_btn       (i_btn_run),
      .press_pulse (run_press_s)
   );

   button_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_btn       (i_btn_clear),
      .press_pulse (clear_press_s)
   );

   // Display mode toggles on every mode press, regardless of FSM state.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         mode_r <= 1'b0;
      end else if (mode_press_s) begin
         mode_r <= ~mode_r;
      end else begin
         mode_r <= mode_r;
      end
   end

   // Next-state logic: clear beats run in STOP, clear is ignored in RUN,
   // CLEAR lasts one cycle and drops anything that arrives meanwhile.
   always_comb begin
      state_next_s = ST_STOP;
      case (state_r)
         ST_STOP: begin
            if (clear_press_s) begin
               state_next_s = ST_CLEAR;
            end else if (run_press_s) begin
               state_next_s = ST_RUN;
            end else begin
               state_next_s = ST_STOP;
            end
         end
         ST_RUN: begin
            if (run_press_s) begin
               state_next_s = ST_STOP;
            end else begin
               state_next_s = ST_RUN;
            end
         end
         ST_CLEAR: begin
            state_next_s = ST_STOP;
         end
         default: begin
            // Unused encoding recovers to a safe stopped state.
            state_next_s = ST_STOP;
         end
      endcase
   end

   // State register plus Moore outputs registered from the next state so
   // they line up exactly with the state they describe.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_r <= ST_STOP;
         run_r   <= 1'b0;
         clear_r <= 1'b0;
      end else begin
         state_r <= state_next_s;
         run_r   <= (state_next_s == ST_RUN);
         clear_r <= (state_next_s == ST_CLEAR);
      end
   end

   assign o_modeSW = mode_r;
   assign o_run    = run_r;
   assign o_clear  = clear_r;
   assign o_state  = state_r;

endmodule

// File: tb/tb_button_ctrl_unit.sv
// Bench for button_ctrl_unit with a short debounce window. Each vector is
// driven on a falling edge; its expected outputs go into a scoreboard queue
// and are popped and compared on the next falling edge, after the rising
// edge that consumes the vector. With DEBOUNCE_CYCLES=4, a button first
// seen at vector i shows its effect on the outputs at vector i+6
// (7 edges after the edge preceding the input change).
module tb_button_ctrl_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_mode;
   logic       btn_run;
   logic       btn_clear;
   logic       o_modeSW;
   logic       o_run;
   logic       o_clear;
   logic [1:0] o_state;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         tag;
      logic       rst;
      logic       m;
      logic       r;
      logic       c;
      logic       em;
      logic       er;
      logic       ec;
      logic [1:0] es;
   } vec_t;

   vec_t       vecs[$];
   logic [4:0] exp_q[$];
   int         tag_q[$];
   int         step_no = 0;

   always #5 clk = ~clk;

   button_ctrl_unit #(.DEBOUNCE_CYCLES(4)) dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_btn_mode  (btn_mode),
      .i_btn_run   (btn_run),
      .i_btn_clear (btn_clear),
      .o_modeSW    (o_modeSW),
      .o_run       (o_run),
      .o_clear     (o_clear),
      .o_state     (o_state)
   );

   function automatic vec_t mk(input int tag, input logic rv, input logic m, input logic r,
                               input logic c, input logic em, input logic er, input logic ec,
                               input logic [1:0] es);
      vec_t v;
      v.tag = tag; v.rst = rv; v.m = m; v.r = r; v.c = c;
      v.em = em; v.er = er; v.ec = ec; v.es = es;
      return v;
   endfunction

   task automatic add(input int n, input int tag, input logic rv, input logic m, input logic r,
                      input logic c, input logic em, input logic er, input logic ec,
                      input logic [1:0] es);
      for (int k = 0; k < n; k++) vecs.push_back(mk(tag, rv, m, r, c, em, er, ec, es));
   endtask

   // Drive one vector (called on a falling edge), then compare one edge later.
   task automatic step(input vec_t v);
      logic [4:0] exp_v;
      logic [4:0] act_v;
      int         t;
      rst       = v.rst;
      btn_mode  = v.m;
      btn_run   = v.r;
      btn_clear = v.c;
      exp_q.push_back({v.em, v.er, v.ec, v.es});
      tag_q.push_back(v.tag);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      t     = tag_q.pop_front();
      act_v = {o_modeSW, o_run, o_clear, o_state};
      checks++;
      if (act_v !== exp_v) begin
         errors++;
         $display("FAIL outputs tag=%0d step=%0d: actual mode,run,clear,state=%b required=%b",
                  t, step_no, act_v, exp_v);
      end
      step_no++;
   endtask

   initial begin
      rst = 1'b1; btn_mode = 1'b0; btn_run = 1'b0; btn_clear = 1'b0;
      @(negedge clk);

      // 1: reset then idle, everything stays quiet
      add(2, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      add(8, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      // 2-4: clean run press held 20, release keeps RUN, second press stops
      add(6,  2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      add(14, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
      add(20, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
      add(6,  4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
      add(4,  4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      add(10, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      // 5: mode bounce 1,0,1,1,0 -- no toggle
      add(1, 5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      add(1, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      add(2, 5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      add(1, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      // 6: final 1 of the pattern starts the steady 1; toggle once, held 50+ more
      add(6,  6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      add(51, 6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
      add(10, 6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
      // 7: run+clear together in STOP -> one CLEAR cycle, run stays 0
      add(6,  7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      add(1,  7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2);
      add(13, 7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      add(10, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
      // 8: enter RUN
      add(6,  8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
      add(4,  8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
      add(10, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
      // 9: clear in RUN is ignored
      add(20, 9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1);
      add(10, 9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
      // 10: mode press in RUN toggles mode only
      add(6,  10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
      add(4,  10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
      add(10, 10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);

      for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

      // 11: run held, reset lands while the counter is at 2, run still held
      // after reset; exactly one press comes out 7 edges after deassertion.
      for (int i = 0; i < 4; i++)  step(mk(11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1));
      for (int i = 0; i < 2; i++)  step(mk(11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
      for (int i = 0; i < 6; i++)  step(mk(12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
      for (int i = 0; i < 30; i++) step(mk(12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1));
      for (int i = 0; i < 10; i++) step(mk(12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1));

      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: actual %0d entries left, required 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
